// File: rtl/parity_check_rx.sv
// Serial receive-side parity checker: rebuilds an MSB-first data word,
// checks the trailing parity bit and counts parity errors.
module parity_check_rx #(
    parameter int DATA_W = 4,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_abort,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] LAST = BC_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BC_W-1:0]   cnt, cnt_n;
    logic              x, x_n;
    logic              done;
    logic              chk;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        x_n     = x;
        done    = 1'b0;
        chk     = x ^ in_bit ^ ODD;
        if (in_abort) begin
            state_n = IDLE;
            sh_n    = '0;
            cnt_n   = '0;
            x_n     = 1'b0;
        end else if (in_valid) begin
            unique case (state)
                IDLE: begin
                    sh_n    = {sh[DATA_W-2:0], in_bit};
                    x_n     = in_bit;
                    cnt_n   = BC_W'(1);
                    state_n = DATA;
                end
                DATA: begin
                    sh_n  = {sh[DATA_W-2:0], in_bit};
                    x_n   = x ^ in_bit;
                    cnt_n = cnt + BC_W'(1);
                    if (cnt_n == LAST) state_n = PARITY;
                end
                PARITY: begin
                    done    = 1'b1;
                    cnt_n   = '0;
                    x_n     = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            x          <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            parity_err <= 1'b0;
            err_cnt    <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            cnt       <= cnt_n;
            x         <= x_n;
            out_valid <= done;
            busy      <= (state_n != IDLE);
            if (done) begin
                out_data   <= sh;
                parity_err <= chk;
                // saturate rather than wrap so a flood of errors stays visible
                if (chk && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_check_rx.sv
// Self-checking bench for parity_check_rx: directed steps plus randomized
// frames checked against a word-level parity model.
module tb_parity_check_rx;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_abort = 1'b0;
    logic          out_valid, out_valid_o;
    logic [DW-1:0] out_data, out_data_o;
    logic          parity_err, parity_err_o;
    logic [CW-1:0] err_cnt, err_cnt_o;
    logic          busy, busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mcnt = 0;
    int mcnt_o = 0;
    int pulse_cyc[$];

    parity_check_rx #(.DATA_W(DW), .ODD(1'b0), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_abort(in_abort), .out_valid(out_valid), .out_data(out_data),
        .parity_err(parity_err), .err_cnt(err_cnt), .busy(busy)
    );

    parity_check_rx #(.DATA_W(DW), .ODD(1'b1), .CNT_W(CW)) dut_odd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_abort(in_abort), .out_valid(out_valid_o), .out_data(out_data_o),
        .parity_err(parity_err_o), .err_cnt(err_cnt_o), .busy(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic a,
                        input logic r, input logic eov);
        in_valid = v;
        in_bit   = b;
        in_abort = a;
        reset    = r;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_abort = 1'b0;
        in_valid = 1'b0;
        chk("out_valid", {31'b0, out_valid}, {31'b0, eov});
        chk("out_valid_odd", {31'b0, out_valid_o}, {31'b0, eov});
        if (out_valid === 1'b1) pulse_cyc.push_back(cyc);
    endtask

    task automatic gap(input int maxgap);
        int n;
        n = $urandom_range(maxgap, 0);
        repeat (n) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input logic p,
                              input int maxgap);
        logic e, eo;
        for (int i = DW - 1; i >= 0; i--) begin
            gap(maxgap);
            step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
        end
        chk("busy_parity", {31'b0, busy}, 32'd1);
        gap(maxgap);
        step(1'b1, p, 1'b0, 1'b0, 1'b1);
        e  = ((($countones(w) + int'(p)) % 2) != 0);
        eo = !e;
        if (e && mcnt < 255) mcnt++;
        if (eo && mcnt_o < 255) mcnt_o++;
        chk("out_data", {28'b0, out_data}, {28'b0, w});
        chk("parity_err", {31'b0, parity_err}, {31'b0, e});
        chk("err_cnt", {24'b0, err_cnt}, 32'(mcnt));
        chk("out_data_odd", {28'b0, out_data_o}, {28'b0, w});
        chk("parity_err_odd", {31'b0, parity_err_o}, {31'b0, eo});
        chk("err_cnt_odd", {24'b0, err_cnt_o}, 32'(mcnt_o));
        chk("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic          p;

        // T1 reset with in_valid toggling
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_data", {28'b0, out_data}, 32'd0);
        chk("rst_perr", {31'b0, parity_err}, 32'd0);
        chk("rst_cnt", {24'b0, err_cnt}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // T2 good frame
        send_frame(4'b1011, 1'b1, 0);

        // T3 bad frame (odd instance sees it as good)
        send_frame(4'b0000, 1'b1, 0);
        chk("t3_cnt", {24'b0, err_cnt}, 32'd1);
        chk("t3_odd_perr", {31'b0, parity_err_o}, 32'd0);

        // T4 abort mid-frame, then a clean frame
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hold", {28'b0, out_data}, 32'd0);
        send_frame(4'b1100, 1'b0, 0);

        // T4 reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        mcnt   = 0;
        mcnt_o = 0;
        chk("rst2_busy", {31'b0, busy}, 32'd0);
        chk("rst2_data", {28'b0, out_data}, 32'd0);
        chk("rst2_cnt", {24'b0, err_cnt}, 32'd0);
        chk("rst2_cnt_odd", {24'b0, err_cnt_o}, 32'd0);

        // T5 random gaps inside frames
        for (int k = 0; k < 20; k++) begin
            w = 4'($urandom);
            p = 1'($urandom);
            send_frame(w, p, 3);
        end

        // T5 back-to-back frames, no gaps
        pulse_cyc.delete();
        send_frame(4'b0110, 1'b0, 0);
        send_frame(4'b1110, 1'b1, 0);
        send_frame(4'b0001, 1'b1, 0);
        chk("b2b_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            chk("b2b_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd5);
            chk("b2b_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd5);
        end

        // T6 saturation: 260 bad frames
        for (int k = 0; k < 260; k++) begin
            w = 4'($urandom);
            p = 1'(($countones(w) + 1) % 2);
            send_frame(w, p, 0);
        end
        chk("sat_cnt", {24'b0, err_cnt}, 32'd255);
        send_frame(4'b0111, 1'b0, 0);
        chk("sat_hold", {24'b0, err_cnt}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
